armleocpu_regfile: RTL and testbench
====================================

# armleocpu_regfile

Two-read, one-write register file for the core's decode/register-read stage, built from two `armleocpu_1r1w` instances. The instances share one write port, and each one serves one read port. The block adds four things on top of the raw memories:
- a post-reset clearing sequencer, since the memories have no reset;
- register index 0 hardwired to zero;
- same-cycle write-to-read bypass, since the memories return old data on a collision;
- registered output selection, so read data is defined from reset onward.

## Interface
Parameters:
- `DEPTH_LOG2`, default 5: address width; `ELEMENTS = 2**DEPTH_LOG2` registers.
- `WIDTH`, default 32: data width.

Ports:
- `clk` in 1: single clock, all logic on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `rs1_addr` in DEPTH_LOG2: read port 1 address.
- `rs1_read` in 1: read port 1 enable.
- `rs1_data` out WIDTH: read port 1 data.
- `rs2_addr` in DEPTH_LOG2: read port 2 address.
- `rs2_read` in 1: read port 2 enable.
- `rs2_data` out WIDTH: read port 2 data.
- `rd_addr` in DEPTH_LOG2: write address.
- `rd_write` in 1: write enable.
- `rd_wdata` in WIDTH: write data.
- `busy` out 1: high while the clearing sequence runs; all external accesses are ignored while it is high.

## Operation
State machine, states INIT and READY.

INIT:
- Entered asynchronously whenever `rst_n` is low; reset mid-sequence restarts from address 0.
- A clear counter (DEPTH_LOG2+1 bits, reset 0) drives the shared write port: address = counter, data = 0, write = 1. The counter increments every cycle.
- When the counter reaches ELEMENTS-1, the write at that address is issued and the next state is READY.
- `rd_*`, `rs1_read` and `rs2_read` are ignored. Read-port select state is unchanged.

READY:
- Memory write enable = `rd_write && rd_addr != 0`. Writes to index 0 are dropped.
- Memory read enable = `rsN_read`. The block stays in READY until reset.

Per read port N, a registered select plus a registered bypass value are updated only when `rsN_read` is high in READY. The select is chosen at the read cycle as follows:
- `rsN_addr == 0` → select ZERO.
- Else if `rd_write` and `rd_addr == rsN_addr` → select BYPASS; capture `rd_wdata` into the bypass register.
- Else → select MEM.

Output mux: ZERO gives 0; BYPASS gives the bypass register; MEM gives the instance's read data.

When `rsN_read` is low, the select and bypass register hold, and the memory read data holds, so `rsN_data` holds its last value.

The two read ports are fully independent. Both may target the same address, and both may bypass the same write.

## Timing
Reset values:
- `busy` = 1.
- State = INIT.
- Clear counter = 0.
- Both selects = ZERO, so `rs1_data` = `rs2_data` = 0.
- Bypass registers = 0.

Clearing and `busy`:
- Clearing takes exactly ELEMENTS cycles after `rst_n` rises.
- `busy` falls on the edge after the write to address ELEMENTS-1, i.e. after ELEMENTS rising edges with `rst_n` high.
- The first accepted access is in the cycle in which `busy` is low.

Read latency: 1 cycle. Address and `rsN_read` are sampled at edge k; `rsN_data` is valid after edge k and stays stable until the next accepted read.

Write and read ordering:
- A write sampled at edge k is visible to a read sampled at edge k through the bypass path.
- The same write is visible to reads sampled at edge k+1 or later through memory.
- A write during INIT is lost. It is not queued.

## Test plan
- Reset release → `busy` high for 32 cycles with defaults, then low. Read every address → all 0, and `rs*_data` = 0 throughout INIT.
- Write 0xDEADBEEF to x5. Read x5 on rs1 the next cycle → `rs1_data` = 0xDEADBEEF one cycle after the read.
- Write 0x12345678 to x7 while reading x7 on both rs1 and rs2 in the same cycle → both outputs = 0x12345678. Then write 0x0 to x7 with no read → both outputs still 0x12345678.
- Write 0xFFFFFFFF to x0, then read x0 with a simultaneous write to x0 → `rs1_data` = 0.
- Read x3 (0xA5) on rs1, then drop `rs1_read` and write 0x5A to x3 → `rs1_data` stays 0xA5 until the next read, which returns 0x5A.
- Assert `rst_n` low at clear counter = 10 after x9 was written → `busy` high for a full 32 cycles again, and a read of x9 afterwards returns 0. A write attempted during INIT is not stored.

Source files
------------

// File: rtl/armleocpu_regfile_if.sv
// Register file access bundle: two read ports, one write port and the busy flag.
interface armleocpu_regfile_if #(
    parameter int unsigned DEPTH_LOG2 = 5,
    parameter int unsigned WIDTH      = 32
);
    logic [DEPTH_LOG2-1:0] rs1_addr;
    logic                  rs1_read;
    logic [WIDTH-1:0]      rs1_data;

    logic [DEPTH_LOG2-1:0] rs2_addr;
    logic                  rs2_read;
    logic [WIDTH-1:0]      rs2_data;

    logic [DEPTH_LOG2-1:0] rd_addr;
    logic                  rd_write;
    logic [WIDTH-1:0]      rd_wdata;

    logic                  busy;

    // Pipeline side driving accesses.
    modport master (
        output rs1_addr, rs1_read, rs2_addr, rs2_read, rd_addr, rd_write, rd_wdata,
        input  rs1_data, rs2_data, busy
    );

    // Register file side.
    modport slave (
        input  rs1_addr, rs1_read, rs2_addr, rs2_read, rd_addr, rd_write, rd_wdata,
        output rs1_data, rs2_data, busy
    );
endinterface

// File: rtl/armleocpu_regfile.sv
// Two-read one-write register file: post-reset clearing, x0 hardwired to zero,
// same-cycle write-to-read bypass and registered read-port selection.

// Raw one-read one-write memory without reset; a read colliding with a write
// returns the old contents.
module armleocpu_1r1w #(
    parameter int unsigned ELEMENTS_W = 5,
    parameter int unsigned WIDTH      = 32
) (
    input  logic                  clk,
    input  logic                  read_en_i,
    input  logic [ELEMENTS_W-1:0] read_addr_i,
    output logic [WIDTH-1:0]      read_data_o,
    input  logic                  write_en_i,
    input  logic [ELEMENTS_W-1:0] write_addr_i,
    input  logic [WIDTH-1:0]      write_data_i
);
    localparam int unsigned Elements = 2 ** ELEMENTS_W;

    logic [WIDTH-1:0] mem_q [Elements];
    logic [WIDTH-1:0] rdata_q;

    // Synchronous read (holds when not enabled) and synchronous write.
    always_ff @(posedge clk) begin
        if (read_en_i) begin
            rdata_q <= mem_q[read_addr_i];
        end
        if (write_en_i) begin
            mem_q[write_addr_i] <= write_data_i;
        end
    end

    assign read_data_o = rdata_q;
endmodule

module armleocpu_regfile #(
    parameter int unsigned DEPTH_LOG2 = 5,
    parameter int unsigned WIDTH      = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    armleocpu_regfile_if.slave    rf
);
    localparam int unsigned ELEMENTS = 2 ** DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] CntLast = (DEPTH_LOG2 + 1)'(ELEMENTS - 1);

    typedef enum logic {StInit, StReady} state_e;
    typedef enum logic [1:0] {SelZero, SelBypass, SelMem} sel_e;

    state_e                state_q, state_d;
    logic [DEPTH_LOG2:0]   clear_cnt_q, clear_cnt_d;
    logic                  busy_q, busy_d;
    sel_e                  rs1_sel_q, rs1_sel_d;
    sel_e                  rs2_sel_q, rs2_sel_d;
    logic [WIDTH-1:0]      rs1_bypass_q, rs1_bypass_d;
    logic [WIDTH-1:0]      rs2_bypass_q, rs2_bypass_d;

    logic                  mem_we;
    logic [DEPTH_LOG2-1:0] mem_waddr;
    logic [WIDTH-1:0]      mem_wdata;
    logic                  rs1_ren, rs2_ren;
    logic [WIDTH-1:0]      rs1_mem_data, rs2_mem_data;

    // Next-state: clearing sequencer in INIT, normal access decode in READY.
    always_comb begin
        state_d      = state_q;
        clear_cnt_d  = clear_cnt_q;
        rs1_sel_d    = rs1_sel_q;
        rs2_sel_d    = rs2_sel_q;
        rs1_bypass_d = rs1_bypass_q;
        rs2_bypass_d = rs2_bypass_q;
        mem_we       = 1'b0;
        mem_waddr    = rf.rd_addr;
        mem_wdata    = rf.rd_wdata;
        rs1_ren      = 1'b0;
        rs2_ren      = 1'b0;

        unique case (state_q)
            StInit: begin
                mem_we      = 1'b1;
                mem_waddr   = clear_cnt_q[DEPTH_LOG2-1:0];
                mem_wdata   = '0;
                clear_cnt_d = clear_cnt_q + 1'b1;
                if (clear_cnt_q == CntLast) begin
                    state_d = StReady;
                end
            end
            StReady: begin
                mem_we  = rf.rd_write && (rf.rd_addr != '0);
                rs1_ren = rf.rs1_read;
                rs2_ren = rf.rs2_read;

                if (rf.rs1_read) begin
                    if (rf.rs1_addr == '0) begin
                        rs1_sel_d = SelZero;
                    end else if (rf.rd_write && (rf.rd_addr == rf.rs1_addr)) begin
                        // Memory would return stale data on this collision.
                        rs1_sel_d    = SelBypass;
                        rs1_bypass_d = rf.rd_wdata;
                    end else begin
                        rs1_sel_d = SelMem;
                    end
                end

                if (rf.rs2_read) begin
                    if (rf.rs2_addr == '0) begin
                        rs2_sel_d = SelZero;
                    end else if (rf.rd_write && (rf.rd_addr == rf.rs2_addr)) begin
                        rs2_sel_d    = SelBypass;
                        rs2_bypass_d = rf.rd_wdata;
                    end else begin
                        rs2_sel_d = SelMem;
                    end
                end
            end
        endcase

        busy_d = (state_d == StInit);
    end

    // Control state, selects and bypass values; reset restarts clearing.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StInit;
            clear_cnt_q  <= '0;
            busy_q       <= 1'b1;
            rs1_sel_q    <= SelZero;
            rs2_sel_q    <= SelZero;
            rs1_bypass_q <= '0;
            rs2_bypass_q <= '0;
        end else begin
            state_q      <= state_d;
            clear_cnt_q  <= clear_cnt_d;
            busy_q       <= busy_d;
            rs1_sel_q    <= rs1_sel_d;
            rs2_sel_q    <= rs2_sel_d;
            rs1_bypass_q <= rs1_bypass_d;
            rs2_bypass_q <= rs2_bypass_d;
        end
    end

    armleocpu_1r1w #(
        .ELEMENTS_W (DEPTH_LOG2),
        .WIDTH      (WIDTH)
    ) u_mem_rs1 (
        .clk          (clk),
        .read_en_i    (rs1_ren),
        .read_addr_i  (rf.rs1_addr),
        .read_data_o  (rs1_mem_data),
        .write_en_i   (mem_we),
        .write_addr_i (mem_waddr),
        .write_data_i (mem_wdata)
    );

    armleocpu_1r1w #(
        .ELEMENTS_W (DEPTH_LOG2),
        .WIDTH      (WIDTH)
    ) u_mem_rs2 (
        .clk          (clk),
        .read_en_i    (rs2_ren),
        .read_addr_i  (rf.rs2_addr),
        .read_data_o  (rs2_mem_data),
        .write_en_i   (mem_we),
        .write_addr_i (mem_waddr),
        .write_data_i (mem_wdata)
    );

    // Output selection from the registered selects.
    always_comb begin
        rf.rs1_data = '0;
        unique case (rs1_sel_q)
            SelZero:   rf.rs1_data = '0;
            SelBypass: rf.rs1_data = rs1_bypass_q;
            SelMem:    rf.rs1_data = rs1_mem_data;
            default:   rf.rs1_data = '0;
        endcase
    end

    // Output selection from the registered selects.
    always_comb begin
        rf.rs2_data = '0;
        unique case (rs2_sel_q)
            SelZero:   rf.rs2_data = '0;
            SelBypass: rf.rs2_data = rs2_bypass_q;
            SelMem:    rf.rs2_data = rs2_mem_data;
            default:   rf.rs2_data = '0;
        endcase
    end

    assign rf.busy = busy_q;
endmodule

// File: tb/tb_armleocpu_regfile.sv
// Directed self-checking bench for armleocpu_regfile.
module tb_armleocpu_regfile;
    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;

    armleocpu_regfile_if #(.DEPTH_LOG2(5), .WIDTH(32)) bus ();

    armleocpu_regfile #(
        .DEPTH_LOG2 (5),
        .WIDTH      (32)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .rf    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one edge and settle away from it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.rs1_addr = '0;
        bus.rs1_read = 1'b0;
        bus.rs2_addr = '0;
        bus.rs2_read = 1'b0;
        bus.rd_addr  = '0;
        bus.rd_write = 1'b0;
        bus.rd_wdata = '0;
    endtask

    // Counts edges until busy drops, with a write to x3 attempted throughout.
    task automatic run_init(output int edges, output int nonzero);
        edges   = 0;
        nonzero = 0;
        bus.rd_write = 1'b1;
        bus.rd_addr  = 5'd3;
        bus.rd_wdata = 32'h3333_3333;
        bus.rs1_read = 1'b1;
        bus.rs1_addr = 5'd3;
        bus.rs2_read = 1'b1;
        bus.rs2_addr = 5'd3;
        while (bus.busy && edges < 40) begin
            tick();
            edges++;
            if (bus.busy && (bus.rs1_data !== 32'h0 || bus.rs2_data !== 32'h0)) nonzero++;
        end
        idle_inputs();
    endtask

    task automatic test_reset();
        int edges, nonzero;
        idle_inputs();
        rst_n = 1'b0;
        #23;
        n_checks++;
        if (bus.busy !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_busy: got %b expected 1", bus.busy);
        end
        n_checks++;
        if (bus.rs1_data !== 32'h0 || bus.rs2_data !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_data: got %h/%h expected 0/0", bus.rs1_data, bus.rs2_data);
        end
        @(negedge clk);
        rst_n = 1'b1;
        run_init(edges, nonzero);
        n_checks++;
        if (edges !== 32) begin
            n_fail++;
            $display("FAIL init_length: got %0d edges expected 32", edges);
        end
        n_checks++;
        if (nonzero !== 0) begin
            n_fail++;
            $display("FAIL init_data_zero: got %0d nonzero cycles expected 0", nonzero);
        end
        // Every register reads zero after clearing.
        for (int i = 0; i < 32; i++) begin
            bus.rs1_read = 1'b1;
            bus.rs1_addr = 5'(i);
            bus.rs2_read = 1'b1;
            bus.rs2_addr = 5'(31 - i);
            tick();
            n_checks++;
            if (bus.rs1_data !== 32'h0 || bus.rs2_data !== 32'h0) begin
                n_fail++;
                $display("FAIL clear_x%0d: got %h/%h expected 0/0", i, bus.rs1_data,
                         bus.rs2_data);
            end
        end
        idle_inputs();
    endtask

    task automatic test_write_read();
        bus.rd_write = 1'b1;
        bus.rd_addr  = 5'd5;
        bus.rd_wdata = 32'hDEAD_BEEF;
        tick();
        idle_inputs();
        bus.rs1_read = 1'b1;
        bus.rs1_addr = 5'd5;
        tick();
        idle_inputs();
        n_checks++;
        if (bus.rs1_data !== 32'hDEAD_BEEF) begin
            n_fail++;
            $display("FAIL write_read_x5: got %h expected deadbeef", bus.rs1_data);
        end
    endtask

    task automatic test_bypass_both();
        bus.rd_write = 1'b1;
        bus.rd_addr  = 5'd7;
        bus.rd_wdata = 32'h1234_5678;
        bus.rs1_read = 1'b1;
        bus.rs1_addr = 5'd7;
        bus.rs2_read = 1'b1;
        bus.rs2_addr = 5'd7;
        tick();
        idle_inputs();
        n_checks++;
        if (bus.rs1_data !== 32'h1234_5678 || bus.rs2_data !== 32'h1234_5678) begin
            n_fail++;
            $display("FAIL bypass_both: got %h/%h expected 12345678/12345678",
                     bus.rs1_data, bus.rs2_data);
        end
        bus.rd_write = 1'b1;
        bus.rd_addr  = 5'd7;
        bus.rd_wdata = 32'h0;
        tick();
        idle_inputs();
        n_checks++;
        if (bus.rs1_data !== 32'h1234_5678 || bus.rs2_data !== 32'h1234_5678) begin
            n_fail++;
            $display("FAIL bypass_hold: got %h/%h expected 12345678/12345678",
                     bus.rs1_data, bus.rs2_data);
        end
        bus.rs2_read = 1'b1;
        bus.rs2_addr = 5'd7;
        tick();
        idle_inputs();
        n_checks++;
        if (bus.rs2_data !== 32'h0 || bus.rs1_data !== 32'h1234_5678) begin
            n_fail++;
            $display("FAIL reread_x7: got %h/%h expected 12345678/00000000",
                     bus.rs1_data, bus.rs2_data);
        end
    endtask

    task automatic test_x0();
        bus.rd_write = 1'b1;
        bus.rd_addr  = 5'd0;
        bus.rd_wdata = 32'hFFFF_FFFF;
        tick();
        bus.rs1_read = 1'b1;
        bus.rs1_addr = 5'd0;
        bus.rs2_read = 1'b1;
        bus.rs2_addr = 5'd0;
        tick();
        idle_inputs();
        n_checks++;
        if (bus.rs1_data !== 32'h0) begin
            n_fail++;
            $display("FAIL x0_bypass: got %h expected 0", bus.rs1_data);
        end
        n_checks++;
        if (bus.rs2_data !== 32'h0) begin
            n_fail++;
            $display("FAIL x0_rs2: got %h expected 0", bus.rs2_data);
        end
    endtask

    task automatic test_hold();
        bus.rd_write = 1'b1;
        bus.rd_addr  = 5'd3;
        bus.rd_wdata = 32'hA5;
        tick();
        idle_inputs();
        bus.rs1_read = 1'b1;
        bus.rs1_addr = 5'd3;
        tick();
        idle_inputs();
        n_checks++;
        if (bus.rs1_data !== 32'hA5) begin
            n_fail++;
            $display("FAIL hold_first: got %h expected a5", bus.rs1_data);
        end
        bus.rs1_addr = 5'd3;
        bus.rd_write = 1'b1;
        bus.rd_addr  = 5'd3;
        bus.rd_wdata = 32'h5A;
        tick();
        idle_inputs();
        tick();
        n_checks++;
        if (bus.rs1_data !== 32'hA5) begin
            n_fail++;
            $display("FAIL hold_stable: got %h expected a5", bus.rs1_data);
        end
        bus.rs1_read = 1'b1;
        bus.rs1_addr = 5'd3;
        tick();
        idle_inputs();
        n_checks++;
        if (bus.rs1_data !== 32'h5A) begin
            n_fail++;
            $display("FAIL hold_reread: got %h expected 5a", bus.rs1_data);
        end
    endtask

    task automatic test_reset_mid();
        int edges, nonzero;
        bus.rd_write = 1'b1;
        bus.rd_addr  = 5'd9;
        bus.rd_wdata = 32'h9999_0009;
        tick();
        idle_inputs();
        bus.rs1_read = 1'b1;
        bus.rs1_addr = 5'd9;
        tick();
        idle_inputs();
        n_checks++;
        if (bus.rs1_data !== 32'h9999_0009) begin
            n_fail++;
            $display("FAIL x9_stored: got %h expected 99990009", bus.rs1_data);
        end
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (bus.busy !== 1'b1 || bus.rs1_data !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_async: got busy=%b data=%h expected 1/0", bus.busy,
                     bus.rs1_data);
        end
        @(negedge clk);
        rst_n = 1'b1;
        // Ten clearing writes, then reset again mid-sequence.
        for (int i = 0; i < 10; i++) tick();
        rst_n = 1'b0;
        #3;
        @(negedge clk);
        rst_n = 1'b1;
        run_init(edges, nonzero);
        n_checks++;
        if (edges !== 32) begin
            n_fail++;
            $display("FAIL restart_length: got %0d edges expected 32", edges);
        end
        n_checks++;
        if (nonzero !== 0) begin
            n_fail++;
            $display("FAIL restart_data_zero: got %0d nonzero cycles expected 0", nonzero);
        end
        bus.rs1_read = 1'b1;
        bus.rs1_addr = 5'd9;
        bus.rs2_read = 1'b1;
        bus.rs2_addr = 5'd3;
        tick();
        idle_inputs();
        n_checks++;
        if (bus.rs1_data !== 32'h0) begin
            n_fail++;
            $display("FAIL x9_cleared: got %h expected 0", bus.rs1_data);
        end
        n_checks++;
        if (bus.rs2_data !== 32'h0) begin
            n_fail++;
            $display("FAIL init_write_lost: got %h expected 0", bus.rs2_data);
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        idle_inputs();
        test_reset();
        test_write_read();
        test_bypass_both();
        test_x0();
        test_hold();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
